zdelta_stream: RTL and testbench

Streaming, parametrised successor to zdelta_core. It takes one (input, feedback) sample pair per beat instead of a fixed 20-plane array, and walks the planes sequentially with an internal counter. Each plane has its own drift integrator, and every input sample is corrected by that plane's integrator before output. It sits between the plane source and the CRT output path, with valid/ready on both sides, and adds freeze, bypass and clear modes plus frame-alignment checking.

---
 rtl/zdelta_stream.sv | 180 ++++++++++++++++++
 tb/tb_zdelta_stream.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/zdelta_stream.sv
// zdelta_stream: streaming per-plane drift corrector with valid/ready on both sides.
// Each accepted beat is corrected by its plane's integrator, which is then updated per mode.
module zdelta_stream #(
  parameter int WIDTH      = 16,
  parameter int PLANES     = 20,
  parameter int ACC_W      = 24,
  parameter int GAIN_SHIFT = 4,
  parameter int IDX_W      = $clog2(PLANES)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       mode,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_in,
  input  logic [WIDTH-1:0] s_fb,
  input  logic             s_last,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data,
  output logic [IDX_W-1:0] m_plane,
  output logic             m_last,
  output logic             align_err,
  input  logic             err_clr
);

  localparam logic [1:0]       MODE_RUN    = 2'b00;
  localparam logic [1:0]       MODE_FREEZE = 2'b01;
  localparam logic [1:0]       MODE_BYPASS = 2'b10;
  localparam logic [1:0]       MODE_CLEAR  = 2'b11;
  localparam logic [IDX_W-1:0] LAST_PLANE  = IDX_W'(PLANES - 1);
  localparam int               SUM_W       = ACC_W + 1;

  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  // Integrators live in flops: the current plane's value is needed combinationally
  // in the accept cycle to keep the one-cycle latency.
  logic signed [ACC_W-1:0] acc_q [PLANES];
  logic [PLANES-1:0]       plane_we;

  logic [IDX_W-1:0] p_q, p_d;
  logic             m_valid_q, m_valid_d;
  logic [WIDTH-1:0] m_data_q, m_data_d;
  logic [IDX_W-1:0] m_plane_q, m_plane_d;
  logic             m_last_q, m_last_d;
  logic             align_err_q, align_err_d;

  logic                    accept;
  logic                    at_last;
  logic                    mismatch;
  logic signed [ACC_W-1:0] acc_cur;
  logic signed [ACC_W-1:0] corr;
  logic signed [WIDTH:0]   e;
  logic signed [SUM_W-1:0] diff;
  logic signed [SUM_W-1:0] sum;
  logic [WIDTH-1:0]        cor_out;
  logic signed [ACC_W-1:0] sat_sum;
  logic signed [ACC_W-1:0] acc_wr_val;
  logic                    acc_we;
  logic [WIDTH-1:0]        beat_data;

  assign s_ready  = !m_valid_q || m_ready;
  assign accept   = s_valid && s_ready;
  assign at_last  = (p_q == LAST_PLANE);
  assign mismatch = (s_last != at_last);

  assign acc_cur = acc_q[p_q];
  assign corr    = acc_cur >>> GAIN_SHIFT;
  assign e       = $signed({1'b0, s_in}) - $signed({1'b0, s_fb});
  assign diff    = $signed({{(SUM_W-WIDTH){1'b0}}, s_in}) - $signed({corr[ACC_W-1], corr});
  assign sum     = $signed({acc_cur[ACC_W-1], acc_cur})
                 + $signed({{(SUM_W-WIDTH-1){e[WIDTH]}}, e});

  // Corrected sample clamped into the unsigned output range.
  always_comb begin
    cor_out = diff[WIDTH-1:0];
    if (diff[SUM_W-1]) begin
      cor_out = '0;
    end else if (|diff[SUM_W-2:WIDTH]) begin
      cor_out = '1;
    end
  end

  // The extra sum bit disagreeing with the ACC_W sign bit means the add overflowed.
  always_comb begin
    sat_sum = sum[ACC_W-1:0];
    if (sum[SUM_W-1] != sum[SUM_W-2]) begin
      sat_sum = sum[SUM_W-1] ? ACC_MIN : ACC_MAX;
    end
  end

  always_comb begin
    acc_we     = 1'b0;
    acc_wr_val = sat_sum;
    beat_data  = cor_out;
    case (mode)
      MODE_RUN: begin
        acc_we = 1'b1;
      end
      MODE_FREEZE: begin
        beat_data = cor_out;
      end
      MODE_BYPASS: begin
        beat_data = s_in;
      end
      MODE_CLEAR: begin
        acc_we     = 1'b1;
        acc_wr_val = '0;
        beat_data  = s_in;
      end
      default: begin
        beat_data = cor_out;
      end
    endcase
  end

  for (genvar gi = 0; gi < PLANES; gi++) begin : g_plane_we
    assign plane_we[gi] = accept && acc_we && (p_q == IDX_W'(gi));
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < PLANES; i++) begin
      if (rst) begin
        acc_q[i] <= '0;
      end else if (plane_we[i]) begin
        acc_q[i] <= acc_wr_val;
      end
    end
  end

  always_comb begin
    p_d         = p_q;
    m_valid_d   = m_valid_q;
    m_data_d    = m_data_q;
    m_plane_d   = m_plane_q;
    m_last_d    = m_last_q;
    align_err_d = align_err_q;
    if (accept) begin
      m_valid_d = 1'b1;
      m_data_d  = beat_data;
      m_plane_d = p_q;
      m_last_d  = at_last;
      // An early s_last resynchronises the counter to plane 0.
      p_d       = (at_last || s_last) ? '0 : p_q + IDX_W'(1);
    end else if (m_ready) begin
      m_valid_d = 1'b0;
    end
    if (accept && mismatch) begin
      align_err_d = 1'b1;
    end else if (err_clr) begin
      align_err_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      p_q         <= '0;
      m_valid_q   <= 1'b0;
      m_data_q    <= '0;
      m_plane_q   <= '0;
      m_last_q    <= 1'b0;
      align_err_q <= 1'b0;
    end else begin
      p_q         <= p_d;
      m_valid_q   <= m_valid_d;
      m_data_q    <= m_data_d;
      m_plane_q   <= m_plane_d;
      m_last_q    <= m_last_d;
      align_err_q <= align_err_d;
    end
  end

  assign m_valid   = m_valid_q;
  assign m_data    = m_data_q;
  assign m_plane   = m_plane_q;
  assign m_last    = m_last_q;
  assign align_err = align_err_q;

endmodule

// File: tb/tb_zdelta_stream.sv
// Self-checking bench for zdelta_stream: scenario tasks against a beat-level reference model.
module tb_zdelta_stream;

  localparam int WIDTH      = 16;
  localparam int PLANES     = 4;
  localparam int ACC_W      = 24;
  localparam int GAIN_SHIFT = 2;
  localparam int IDX_W      = $clog2(PLANES);
  localparam longint ACC_MAX = (longint'(1) << (ACC_W - 1)) - 1;
  localparam longint ACC_MIN = -(longint'(1) << (ACC_W - 1));
  localparam longint OUT_MAX = (longint'(1) << WIDTH) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [1:0]       mode = 2'b00;
  logic             s_valid = 1'b0;
  logic             s_ready;
  logic [WIDTH-1:0] s_in = '0;
  logic [WIDTH-1:0] s_fb = '0;
  logic             s_last = 1'b0;
  logic             m_valid;
  logic             m_ready = 1'b0;
  logic [WIDTH-1:0] m_data;
  logic [IDX_W-1:0] m_plane;
  logic             m_last;
  logic             align_err;
  logic             err_clr = 1'b0;

  zdelta_stream #(
    .WIDTH(WIDTH), .PLANES(PLANES), .ACC_W(ACC_W), .GAIN_SHIFT(GAIN_SHIFT), .IDX_W(IDX_W)
  ) dut (
    .clk(clk), .rst(rst), .mode(mode), .s_valid(s_valid), .s_ready(s_ready),
    .s_in(s_in), .s_fb(s_fb), .s_last(s_last), .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data), .m_plane(m_plane), .m_last(m_last), .align_err(align_err),
    .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: integrators, frame position and the output beat the DUT should present.
  longint acc_m [PLANES];
  int     p_m;
  bit     mv_m, ml_m, ae_m, sr_exp;
  int     md_m, mp_m;
  logic   sr_dut;

  function automatic bit aligned();
    return (p_m == PLANES - 1);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < PLANES; i++) acc_m[i] = 0;
    p_m = 0; mv_m = 0; ml_m = 0; ae_m = 0; md_m = 0; mp_m = 0;
  endtask

  task automatic do_reset(input bit sv);
    rst = 1'b1; s_valid = sv; m_ready = 1'b1; err_clr = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0; s_valid = 1'b0;
    model_reset();
  endtask

  // One clock of stimulus; called just after a rising edge, returns 1 time unit after the next.
  task automatic step(input bit sv, input bit mr, input int md, input int sin, input int sfb,
                      input bit sl, input bit ec);
    longint e, corr, cor, sum;
    bit acc_ok, lastp;
    rst = 1'b0; s_valid = sv; m_ready = mr; mode = 2'(md);
    s_in = WIDTH'(sin); s_fb = WIDTH'(sfb); s_last = sl; err_clr = ec;
    #1;
    sr_exp = !mv_m || mr;
    sr_dut = s_ready;
    acc_ok = sv && sr_exp;
    @(posedge clk); #1;
    if (acc_ok) begin
      e    = longint'(sin) - longint'(sfb);
      corr = acc_m[p_m] >>> GAIN_SHIFT;
      cor  = longint'(sin) - corr;
      if (cor < 0) cor = 0;
      else if (cor > OUT_MAX) cor = OUT_MAX;
      md_m = (md >= 2) ? sin : int'(cor);
      if (md == 0) begin
        sum = acc_m[p_m] + e;
        if (sum > ACC_MAX) sum = ACC_MAX;
        else if (sum < ACC_MIN) sum = ACC_MIN;
        acc_m[p_m] = sum;
      end else if (md == 3) begin
        acc_m[p_m] = 0;
      end
      lastp = (p_m == PLANES - 1);
      mp_m = p_m; ml_m = lastp; mv_m = 1'b1;
      if (sl != lastp) ae_m = 1'b1;
      else if (ec) ae_m = 1'b0;
      p_m = (lastp || sl) ? 0 : p_m + 1;
      $display("beat plane=%0d mode=%0d in=%0d fb=%0d last=%0b -> data=%0d err=%0b",
               mp_m, md, sin, sfb, sl, md_m, ae_m);
    end else begin
      if (mr) mv_m = 1'b0;
      if (ec) ae_m = 1'b0;
    end
  endtask

  task automatic test_reset();
    do_reset(1'b0);
    vectors++;
    if (m_valid !== 1'b0 || align_err !== 1'b0 || m_data !== '0 || m_plane !== '0 ||
        m_last !== 1'b0 || s_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset: got v=%0b e=%0b d=%0d p=%0d l=%0b r=%0b, want all 0 and ready=1",
               m_valid, align_err, m_data, m_plane, m_last, s_ready);
    end
  endtask

  task automatic test_steady();
    do_reset(1'b0);
    for (int b = 0; b < 2 * PLANES; b++) begin
      step(1, 1, 0, 1000, 1000, aligned(), 0);
      vectors++;
      if (m_valid !== 1'b1 || m_data !== 16'd1000 || m_plane !== IDX_W'(b % PLANES) ||
          m_last !== ((b % PLANES) == PLANES - 1) || align_err !== 1'b0) begin
        miscompares++;
        $display("FAIL steady: got v=%0b d=%0d p=%0d l=%0b e=%0b, want v=1 d=1000 p=%0d l=%0b e=0",
                 m_valid, m_data, m_plane, m_last, align_err, b % PLANES,
                 (b % PLANES) == PLANES - 1);
      end
    end
  endtask

  task automatic test_drift();
    int want [3];
    want[0] = 1000; want[1] = 998; want[2] = 995;
    do_reset(1'b0);
    for (int f = 0; f < 3; f++) begin
      for (int pl = 0; pl < PLANES; pl++) begin
        step(1, 1, 0, 1000, (pl == 0) ? 990 : 1000, aligned(), 0);
        vectors++;
        if (m_valid !== mv_m || m_data !== WIDTH'(md_m) || m_plane !== IDX_W'(mp_m) ||
            (pl == 0 && m_data !== WIDTH'(want[f]))) begin
          miscompares++;
          $display("FAIL drift f%0d p%0d: got d=%0d p=%0d, want d=%0d p=%0d",
                   f, pl, m_data, m_plane, (pl == 0) ? want[f] : md_m, mp_m);
        end
      end
    end
  endtask

  task automatic test_saturation();
    do_reset(1'b0);
    for (int f = 0; f < 100; f++)
      for (int pl = 0; pl < PLANES; pl++)
        step(1, 1, 0, (pl == 1) ? 1004 : 700, 700 + ((pl == 1) ? 300 : 0), aligned(), 0);
    step(1, 1, 0, 700, 700, aligned(), 0);
    step(1, 1, 0, 3, 3, aligned(), 0);
    vectors++;
    if (m_data !== 16'd0 || m_data !== WIDTH'(md_m) || m_plane !== 2'd1) begin
      miscompares++;
      $display("FAIL sat_low: got d=%0d p=%0d, want d=0 p=1", m_data, m_plane);
    end
    step(1, 1, 0, 700, 700, aligned(), 0);
    step(1, 1, 0, 700, 700, aligned(), 0);
    for (int f = 0; f < 130; f++) begin
      for (int pl = 0; pl < PLANES; pl++) begin
        step(1, 1, 0, (pl == 1) ? 65535 : 700, (pl == 1) ? 0 : 700, aligned(), 0);
        vectors++;
        if (m_valid !== 1'b1 || m_data !== WIDTH'(md_m) || m_plane !== IDX_W'(mp_m)) begin
          miscompares++;
          $display("FAIL sat_run f%0d p%0d: got d=%0d p=%0d, want d=%0d p=%0d",
                   f, pl, m_data, m_plane, md_m, mp_m);
        end
      end
    end
    // A wrapped (negative) integrator would push this to full scale instead of 0.
    step(1, 1, 0, 700, 700, aligned(), 0);
    step(1, 1, 1, 65535, 0, aligned(), 0);
    vectors++;
    if (m_data !== 16'd0 || m_plane !== 2'd1) begin
      miscompares++;
      $display("FAIL sat_clamp: got d=%0d p=%0d, want d=0 p=1", m_data, m_plane);
    end
    step(1, 1, 0, 700, 700, aligned(), 0);
    step(1, 1, 0, 700, 700, aligned(), 0);
  endtask

  task automatic test_stall();
    int held;
    step(0, 1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 2000, 1990, aligned(), 0);
    held = md_m;
    vectors++;
    if (m_valid !== 1'b1 || m_data !== WIDTH'(held) || sr_dut !== 1'b1) begin
      miscompares++;
      $display("FAIL stall_first: got v=%0b d=%0d r=%0b, want v=1 d=%0d r=1",
               m_valid, m_data, sr_dut, held);
    end
    for (int i = 0; i < 4; i++) begin
      step(1, 0, 0, 3000 + i, 100, aligned(), 0);
      vectors++;
      if (sr_dut !== 1'b0 || m_valid !== 1'b1 || m_data !== WIDTH'(held) ||
          m_plane !== IDX_W'(mp_m)) begin
        miscompares++;
        $display("FAIL stall_hold%0d: got r=%0b v=%0b d=%0d p=%0d, want r=0 v=1 d=%0d p=%0d",
                 i, sr_dut, m_valid, m_data, m_plane, held, mp_m);
      end
    end
    for (int i = 0; i < 2 * PLANES; i++) begin
      step(1, 1, 0, 2000, 1990, aligned(), 0);
      vectors++;
      if (sr_dut !== 1'b1 || m_valid !== 1'b1 || m_data !== WIDTH'(md_m) ||
          m_plane !== IDX_W'(mp_m)) begin
        miscompares++;
        $display("FAIL stall_resume%0d: got r=%0b d=%0d p=%0d, want r=1 d=%0d p=%0d",
                 i, sr_dut, m_data, m_plane, md_m, mp_m);
      end
    end
  endtask

  task automatic test_align();
    do_reset(1'b0);
    step(1, 1, 0, 1000, 1000, 0, 0);
    step(1, 1, 0, 1000, 1000, 0, 0);
    step(1, 1, 0, 1000, 1000, 1, 0);
    vectors++;
    if (align_err !== 1'b1 || m_plane !== 2'd2) begin
      miscompares++;
      $display("FAIL align_set: got e=%0b p=%0d, want e=1 p=2", align_err, m_plane);
    end
    step(1, 1, 0, 1000, 1000, 0, 0);
    vectors++;
    if (m_plane !== 2'd0 || align_err !== 1'b1) begin
      miscompares++;
      $display("FAIL align_resync: got p=%0d e=%0b, want p=0 e=1", m_plane, align_err);
    end
    step(0, 1, 0, 0, 0, 0, 1);
    vectors++;
    if (align_err !== 1'b0) begin
      miscompares++;
      $display("FAIL align_clr: got e=%0b, want 0", align_err);
    end
    step(1, 1, 0, 1000, 1000, 1, 1);
    vectors++;
    if (align_err !== 1'b1 || m_plane !== 2'd1) begin
      miscompares++;
      $display("FAIL align_set_wins: got e=%0b p=%0d, want e=1 p=1", align_err, m_plane);
    end
    step(0, 1, 0, 0, 0, 0, 1);
    vectors++;
    if (align_err !== 1'b0) begin
      miscompares++;
      $display("FAIL align_clr2: got e=%0b, want 0", align_err);
    end
  endtask

  task automatic test_modes();
    int md_seq [4];
    int want [4];
    md_seq[0] = 1; md_seq[1] = 2; md_seq[2] = 3; md_seq[3] = 1;
    want[0] = 995; want[1] = 1000; want[2] = 1000; want[3] = 1000;
    do_reset(1'b0);
    for (int f = 0; f < 2; f++)
      for (int pl = 0; pl < PLANES; pl++)
        step(1, 1, 0, 1000, (pl == 0) ? 990 : 1000, aligned(), 0);
    for (int k = 0; k < 4; k++) begin
      step(1, 1, md_seq[k], 1000, 0, aligned(), 0);
      vectors++;
      if (m_data !== WIDTH'(want[k]) || m_plane !== 2'd0 || m_valid !== 1'b1) begin
        miscompares++;
        $display("FAIL mode%0d: got d=%0d p=%0d v=%0b, want d=%0d p=0 v=1",
                 md_seq[k], m_data, m_plane, m_valid, want[k]);
      end
      for (int pl = 1; pl < PLANES; pl++) step(1, 1, 0, 500, 500, aligned(), 0);
    end
    step(1, 1, 0, 500, 500, aligned(), 0);
    step(1, 1, 0, 500, 500, aligned(), 0);
    do_reset(1'b1);
    vectors++;
    if (m_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL midframe_rst: got v=%0b, want 0", m_valid);
    end
    step(1, 1, 0, 500, 500, aligned(), 0);
    vectors++;
    if (m_plane !== 2'd0 || m_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL post_rst_plane: got p=%0d v=%0b, want p=0 v=1", m_plane, m_valid);
    end
  endtask

  task automatic test_random();
    bit sv, mr, sl, ec;
    int md;
    for (int c = 0; c < 400; c++) begin
      sv = ($urandom_range(0, 3) != 0);
      mr = ($urandom_range(0, 3) != 0);
      md = int'($urandom_range(0, 3));
      sl = aligned() ^ ($urandom_range(0, 15) == 0);
      ec = ($urandom_range(0, 7) == 0);
      step(sv, mr, md, int'($urandom_range(0, 65535)), int'($urandom_range(0, 65535)), sl, ec);
      vectors++;
      if (sr_dut !== sr_exp || m_valid !== mv_m || align_err !== ae_m ||
          (mv_m && (m_data !== WIDTH'(md_m) || m_plane !== IDX_W'(mp_m) || m_last !== ml_m))) begin
        miscompares++;
        $display("FAIL random c%0d: got r=%0b v=%0b d=%0d p=%0d l=%0b e=%0b, want r=%0b v=%0b d=%0d p=%0d l=%0b e=%0b",
                 c, sr_dut, m_valid, m_data, m_plane, m_last, align_err,
                 sr_exp, mv_m, md_m, mp_m, ml_m, ae_m);
      end
    end
  endtask

  initial begin
    model_reset();
    @(posedge clk); #1;
    test_reset();
    test_steady();
    test_drift();
    test_saturation();
    test_stall();
    test_align();
    test_modes();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
